// File: rtl/gbt_link_pkg.sv
// Framing constants and types shared by the GBT e-link transmit framer and receiver.
// Keeping them here gives both ends a single definition of the frame layout.
package gbt_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_A1   = 3'd2,
        ST_A2   = 3'd3,
        ST_D0   = 3'd4,
        ST_D1   = 3'd5,
        ST_D2   = 3'd6,
        ST_END  = 3'd7
    } gbt_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } gbt_req_t;

    localparam int          FRAME_LEN         = 7;
    localparam logic [11:0] FRAME_END_DEFAULT = 12'hABC;
    localparam logic [11:0] IDLE_PAYLOAD      = 12'h000;
    localparam int          HDR_VALID_BIT     = 11;
    localparam int          HDR_WE_BIT        = 10;

    // 12-bit payload carried by the word that belongs to frame position st.
    function automatic logic [11:0] frame_payload(input gbt_state_e st,
                                                  input gbt_req_t r,
                                                  input logic [11:0] frame_end);
        logic [11:0] p;
        p = IDLE_PAYLOAD;
        case (st)
            ST_HDR: begin
                p = {4'h0, r.addr[31:24]};
                p[HDR_VALID_BIT] = 1'b1;
                p[HDR_WE_BIT]    = r.we;
            end
            ST_A1:   p = r.addr[23:12];
            ST_A2:   p = r.addr[11:0];
            ST_D0:   p = {4'h0, r.data[31:24]};
            ST_D1:   p = r.data[23:12];
            ST_D2:   p = r.data[11:0];
            ST_END:  p = frame_end;
            default: p = IDLE_PAYLOAD;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/link_gbt_tx_fifo.sv
// Request FIFO for the GBT transmit framer; pointers carry one extra wrap bit
// so that full and empty are distinguishable without a separate counter.
module link_gbt_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem[rd_ptr_r[AW-1:0]];

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/link_gbt_tx_framer.sv
// Frames 32-bit register-access requests into 7-word GBT e-link frames,
// with the registered TTC nibble carried in the top bits of every word.
module link_gbt_tx_framer
    import gbt_link_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [11:0] FRAME_END  = FRAME_END_DEFAULT
) (
    input  logic        ttc_clk_40_i,
    input  logic        reset_i,
    input  logic [3:0]  ttc_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic [15:0] gbt_tx_data_o,
    output logic        busy_o,
    output logic [15:0] frames_sent_o
);
    gbt_state_e state_r;
    gbt_req_t   hold_r;
    gbt_req_t   fifo_wr_s;
    gbt_req_t   fifo_rd_s;
    logic [3:0] ttc_r;
    logic       fifo_empty_s;
    logic       fifo_full_s;
    logic       fifo_pop_s;

    assign fifo_wr_s   = '{we: req_we_i, addr: req_addr_i, data: req_data_i};
    assign fifo_pop_s  = ((state_r == ST_IDLE) || (state_r == ST_END)) && !fifo_empty_s;
    assign req_ready_o = !fifo_full_s;
    assign busy_o      = (state_r != ST_IDLE) || !fifo_empty_s;

    link_gbt_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(gbt_req_t))
    ) u_fifo (
        .clk     (ttc_clk_40_i),
        .reset   (reset_i),
        .push    (req_valid_i),
        .wr_data (fifo_wr_s),
        .pop     (fifo_pop_s),
        .rd_data (fifo_rd_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    // Frame FSM with registered word output; the word reflects the state held
    // during the previous cycle, which keeps TTC and payload on the same pipeline depth.
    always_ff @(posedge ttc_clk_40_i) begin
        if (reset_i) begin
            state_r       <= ST_IDLE;
            hold_r        <= '0;
            ttc_r         <= 4'h0;
            gbt_tx_data_o <= 16'h0000;
            frames_sent_o <= 16'h0000;
        end else begin
            ttc_r         <= ttc_i;
            gbt_tx_data_o <= {ttc_r, frame_payload(state_r, hold_r, FRAME_END)};
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        hold_r  <= fifo_rd_s;
                        state_r <= ST_HDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HDR: state_r <= ST_A1;
                ST_A1:  state_r <= ST_A2;
                ST_A2:  state_r <= ST_D0;
                ST_D0:  state_r <= ST_D1;
                ST_D1:  state_r <= ST_D2;
                ST_D2:  state_r <= ST_END;
                ST_END: begin
                    frames_sent_o <= frames_sent_o + 16'd1;
                    if (!fifo_empty_s) begin
                        hold_r  <= fifo_rd_s;
                        state_r <= ST_HDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
